// File: rtl/game_pkg.sv
// Shared types and helpers for the pinball game-flow controller.
//   state_t        : top-level game flow states
//   LIVES_DEF      : default balls per game
//   LEVEL_MAX_DEF  : default last level (0-based)
//   popcount()     : number of set bits in a vector of up to 64 bits
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    PAUSED    = 3'd2,
    BALL_LOST = 3'd3,
    LEVEL_UP  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam int LIVES_DEF     = 3;
  localparam int LEVEL_MAX_DEF = 3;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/game_flow_controller_key_edge_detect.sv
// Registered rising-edge detector for already-synchronised, level-sensitive
// keys. key_edge is high for exactly one clk, one cycle after the key is
// first seen high, so a held key produces a single edge.
//   clk, resetN : clock, asynchronous active-low reset
//   key         : W level-sensitive key inputs
//   key_edge    : W one-clk rising-edge pulses
module key_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [W-1:0] key,
  output logic [W-1:0] key_edge
);

  logic [W-1:0] key_prev_q, key_prev_d;
  logic [W-1:0] key_edge_q, key_edge_d;

  always_comb begin
    key_prev_d = key;
    key_edge_d = key & ~key_prev_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_prev_q <= '0;
      key_edge_q <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      key_edge_q <= key_edge_d;
    end
  end

  assign key_edge = key_edge_q;

endmodule

// File: rtl/game_flow_controller.sv
// Pinball game-flow controller. Turns per-pixel draw flags into per-frame
// de-duplicated hit pulses and runs the IDLE/PLAY/PAUSED/BALL_LOST/LEVEL_UP/
// GAME_OVER flow that drives the ball mover and display overlays.
//   draw_ball/draw_obj/draw_bottom_border : pixel-level draw flags
//   startOfFrame   : one-clk frame strobe (clears hit flags, blanking cycle)
//   level_cleared  : one-clk strobe from the target logic
//   key_start/key_pause : synchronised keys, acted on at their rising edge
//   collision      : combinational ball/object overlap, any state
//   hit_pulse      : registered first overlap per object per frame, PLAY only
//   score/lives/level/pause/reset_level/game_over/win : game status
//   dbg_state      : current flow state for observation
module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_OBJ         = 4,
  parameter int LIVES           = LIVES_DEF,
  parameter int LEVEL_MAX       = LEVEL_MAX_DEF,
  parameter int SCORE_W         = 16,
  parameter int POINTS          = 1,
  parameter int RELAUNCH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               draw_ball,
  input  logic [NUM_OBJ-1:0] draw_obj,
  input  logic               draw_bottom_border,
  input  logic               level_cleared,
  input  logic               key_start,
  input  logic               key_pause,
  output logic [NUM_OBJ-1:0] collision,
  output logic [NUM_OBJ-1:0] hit_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [1:0]         level,
  output logic               pause,
  output logic               reset_level,
  output logic               game_over,
  output logic               win,
  output state_t             dbg_state
);

  localparam int CNT_W = (RELAUNCH_FRAMES > 1) ? $clog2(RELAUNCH_FRAMES) : 1;
  localparam int SUM_W = SCORE_W + 4;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [1:0]         level_q, level_d;
  logic [NUM_OBJ-1:0] flags_q, flags_d;
  logic [NUM_OBJ-1:0] hit_pulse_q, hit_pulse_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               reset_level_q, reset_level_d;
  logic               win_q, win_d;

  logic [1:0]         key_edge;
  logic               start_edge, pause_edge, bottom_hit;
  logic [NUM_OBJ-1:0] new_hits;
  logic [SUM_W-1:0]   score_sum;

  key_edge_detect #(.W(2)) u_keys (
    .clk      (clk),
    .resetN   (resetN),
    .key      ({key_pause, key_start}),
    .key_edge (key_edge)
  );

  assign start_edge = key_edge[0];
  assign pause_edge = key_edge[1];
  assign collision  = draw_obj & {NUM_OBJ{draw_ball}};
  assign bottom_hit = draw_ball & draw_bottom_border;

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    level_d       = level_q;
    flags_d       = flags_q;
    frame_cnt_d   = frame_cnt_q;
    win_d         = win_q;
    reset_level_d = 1'b0;
    new_hits      = '0;

    // Frame start clears the per-frame flags; a paused game keeps them so a
    // resumed frame does not re-score objects already hit.
    if (startOfFrame && state_q != PAUSED) flags_d = '0;

    // The frame-start cycle itself is blanking: overlaps there are ignored.
    if (state_q == PLAY && !startOfFrame) begin
      new_hits = collision & ~flags_q;
      flags_d  = flags_q | new_hits;
    end
    hit_pulse_d = new_hits;

    // Wide sum so a large increment can be detected and clamped, never wrapped.
    score_sum = SUM_W'(score_q) + SUM_W'(POINTS * popcount(64'(new_hits)));
    if (score_sum[SUM_W-1:SCORE_W] != '0) score_d = '1;
    else                                  score_d = score_sum[SCORE_W-1:0];

    case (state_q)
      IDLE: begin
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (bottom_hit) begin
          lives_d = lives_q - 3'd1;
          if (lives_q > 3'd1) begin
            state_d       = BALL_LOST;
            reset_level_d = 1'b1;
            frame_cnt_d   = '0;
          end else begin
            state_d = GAME_OVER;
            win_d   = 1'b0;
          end
        end else if (level_cleared) begin
          state_d = LEVEL_UP;
        end else if (pause_edge) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_edge) state_d = PLAY;
      end
      BALL_LOST: begin
        if (startOfFrame) begin
          if (frame_cnt_q == CNT_W'(RELAUNCH_FRAMES - 1)) begin
            frame_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      LEVEL_UP: begin
        if (level_q == 2'(LEVEL_MAX)) begin
          state_d = GAME_OVER;
          win_d   = 1'b1;
        end else begin
          level_d       = level_q + 2'd1;
          reset_level_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GAME_OVER: begin
        if (start_edge) begin
          state_d = IDLE;
          score_d = '0;
          lives_d = 3'(LIVES);
          level_d = '0;
          win_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      score_q       <= '0;
      lives_q       <= 3'(LIVES);
      level_q       <= '0;
      flags_q       <= '0;
      hit_pulse_q   <= '0;
      frame_cnt_q   <= '0;
      reset_level_q <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      flags_q       <= flags_d;
      hit_pulse_q   <= hit_pulse_d;
      frame_cnt_q   <= frame_cnt_d;
      reset_level_q <= reset_level_d;
      win_q         <= win_d;
    end
  end

  assign hit_pulse   = hit_pulse_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign reset_level = reset_level_q;
  assign win         = win_q;
  assign pause       = (state_q != PLAY);
  assign game_over   = (state_q == GAME_OVER);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller. Two instances share all stimulus: one with
// a 16-bit score and one with a 3-bit score so saturation is reached quickly.
// Expected values come from a game-rules model (modes, per-frame hit sets).
module tb_game_flow_controller;
  import game_pkg::*;

  localparam int NOBJ     = 4;
  localparam int SMALL_W  = 3;
  localparam int RELAUNCH = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSED = 2, M_LOST = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0, draw_ball = 1'b0, draw_bottom = 1'b0, level_cleared = 1'b0;
  logic key_start = 1'b0, key_pause = 1'b0;
  logic [NOBJ-1:0] draw_obj = '0;

  logic [NOBJ-1:0] collision, hit_pulse, coll_s, hp_s;
  logic [15:0] score;
  logic [SMALL_W-1:0] score_s;
  logic [2:0] lives, lives_s;
  logic [1:0] level, level_s;
  logic pause, reset_level, game_over, win;
  logic pause_s, rl_s, go_s, win_s;
  state_t dbg_a, dbg_b;

  game_flow_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_ball(draw_ball),
    .draw_obj(draw_obj), .draw_bottom_border(draw_bottom),
    .level_cleared(level_cleared), .key_start(key_start), .key_pause(key_pause),
    .collision(collision), .hit_pulse(hit_pulse), .score(score), .lives(lives),
    .level(level), .pause(pause), .reset_level(reset_level),
    .game_over(game_over), .win(win), .dbg_state(dbg_a)
  );

  game_flow_controller #(.SCORE_W(SMALL_W)) dut_small (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_ball(draw_ball),
    .draw_obj(draw_obj), .draw_bottom_border(draw_bottom),
    .level_cleared(level_cleared), .key_start(key_start), .key_pause(key_pause),
    .collision(coll_s), .hit_pulse(hp_s), .score(score_s), .lives(lives_s),
    .level(level_s), .pause(pause_s), .reset_level(rl_s),
    .game_over(go_s), .win(win_s), .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  // Reference model state
  int mode, exp_score, exp_small, exp_lives, exp_level, lost_left, exp_rl, obs_rl;
  bit exp_win;
  logic [NOBJ-1:0] frame_set;
  int exp_pulse[NOBJ];
  int obs_pulse[NOBJ];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NOBJ; i++) if (hit_pulse[i]) obs_pulse[i]++;
    if (reset_level) obs_rl++;
  endtask

  task automatic model_reset();
    mode = M_IDLE; exp_score = 0; exp_small = 0; exp_lives = 3; exp_level = 0;
    exp_win = 0; frame_set = '0; lost_left = 0;
  endtask

  task automatic check_all(input string t);
    check({t, "_score"}, 32'(score), 32'(exp_score));
    check({t, "_score_small"}, 32'(score_s), 32'(exp_small));
    check({t, "_lives"}, 32'(lives), 32'(exp_lives));
    check({t, "_level"}, 32'(level), 32'(exp_level));
    check({t, "_pause"}, 32'(pause), 32'(mode != M_PLAY));
    check({t, "_game_over"}, 32'(game_over), 32'(mode == M_OVER));
    check({t, "_win"}, 32'(win), 32'(exp_win));
    check({t, "_reset_level_count"}, 32'(obs_rl), 32'(exp_rl));
    for (int i = 0; i < NOBJ; i++)
      check($sformatf("%s_pulses%0d", t, i), 32'(obs_pulse[i]), 32'(exp_pulse[i]));
  endtask

  // One clock of pixel inputs, applied to the model by the game rules.
  task automatic step(input bit s, input bit b, input logic [NOBJ-1:0] o, input bit bot);
    logic [NOBJ-1:0] nh;
    int n;
    sof = s; draw_ball = b; draw_obj = o; draw_bottom = bot;
    #1 check("collision", 32'(collision), 32'(o & {NOBJ{b}}));
    if (s && mode != M_PAUSED) frame_set = '0;
    if (mode == M_PLAY) begin
      if (!s && b) begin
        nh = o & ~frame_set;
        frame_set = frame_set | nh;
        n = $countones(nh);
        for (int i = 0; i < NOBJ; i++) if (nh[i]) exp_pulse[i]++;
        exp_score = (exp_score + n > 65535) ? 65535 : exp_score + n;
        exp_small = (exp_small + n > 7) ? 7 : exp_small + n;
      end
      if (b && bot) begin
        exp_lives--;
        if (exp_lives > 0) begin
          mode = M_LOST; lost_left = RELAUNCH; exp_rl++;
        end else begin
          mode = M_OVER; exp_win = 0;
        end
      end
    end else if (mode == M_LOST && s) begin
      lost_left--;
      if (lost_left == 0) mode = M_IDLE;
    end
    tick();
    sof = 0; draw_ball = 0; draw_obj = '0; draw_bottom = 0;
  endtask

  task automatic press_start();
    key_start = 1; tick(); key_start = 0; tick();
    if (mode == M_IDLE) mode = M_PLAY;
    else if (mode == M_OVER) begin
      mode = M_IDLE; exp_score = 0; exp_small = 0; exp_lives = 3; exp_level = 0; exp_win = 0;
    end
  endtask

  task automatic press_pause();
    key_pause = 1; tick(); key_pause = 0; tick();
    if (mode == M_PLAY) mode = M_PAUSED;
    else if (mode == M_PAUSED) mode = M_PLAY;
  endtask

  task automatic clear_level();
    level_cleared = 1; tick(); level_cleared = 0; tick();
    if (mode == M_PLAY) begin
      if (exp_level == 3) begin mode = M_OVER; exp_win = 1; end
      else begin exp_level++; exp_rl++; mode = M_IDLE; end
    end
  endtask

  task automatic random_frame();
    step(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
    repeat ($urandom_range(2, 6))
      step(0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 0);
  endtask

  task automatic lose_ball(input string t);
    random_frame();
    step(0, 1, 4'($urandom_range(0, 15)), 1);
    check_all({t, "_after_bottom"});
  endtask

  task automatic wait_relaunch(input string t);
    // 59 frames: still in BALL_LOST, a start edge must be ignored.
    repeat (RELAUNCH - 1) begin step(1, 0, '0, 0); tick(); end
    press_start();
    check_all({t, "_before_relaunch"});
    step(1, 0, '0, 0); tick();
    press_start();
    check_all({t, "_relaunched"});
  endtask

  initial begin
    for (int i = 0; i < NOBJ; i++) begin exp_pulse[i] = 0; obs_pulse[i] = 0; end
    exp_rl = 0; obs_rl = 0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check_all("reset");
    check("reset_hit_pulse", 32'(hit_pulse), 32'd0);
    check("reset_reset_level", 32'(reset_level), 32'd0);
    @(negedge clk); resetN = 1;
    tick();

    press_start();
    check_all("start");

    // Held overlap on object 2 scores once per frame
    step(1, 0, '0, 0);
    repeat (5) step(0, 1, 4'b0100, 0);
    check("obj2_score_frame1", 32'(score), 32'd1);
    check_all("obj2_frame1");
    step(1, 0, '0, 0);
    repeat (5) step(0, 1, 4'b0100, 0);
    check("obj2_score_frame2", 32'(score), 32'd2);
    check_all("obj2_frame2");

    // Two objects in one cycle
    step(1, 0, '0, 0);
    step(0, 1, 4'b1001, 0);
    check("dual_hit_pulse", 32'(hit_pulse), 32'h9);
    check("dual_score", 32'(score), 32'd4);
    check_all("dual");

    // Blanking: overlap on the frame-start cycle only
    step(1, 1, 4'b1111, 0);
    tick();
    check_all("blanking");

    // Random play; small score saturates at 7
    repeat (12) begin
      random_frame();
      check_all("random");
    end
    check("small_saturated", 32'(score_s), 32'd7);

    // Pause: flags held across a paused frame start
    step(1, 0, '0, 0);
    step(0, 1, 4'b0010, 0);
    press_pause();
    check_all("paused");
    step(1, 0, '0, 0);
    repeat (3) step(0, 1, 4'b1111, 0);
    check_all("paused_overlap");
    press_pause();
    step(0, 1, 4'b0010, 0);
    check_all("resumed_flag_held");
    key_pause = 1;
    repeat (100) tick();
    key_pause = 0; tick();
    if (mode == M_PLAY) mode = M_PAUSED;
    check_all("pause_held");
    press_pause();
    check_all("unpaused");

    // Level progression
    for (int l = 0; l < 3; l++) begin
      clear_level();
      check_all($sformatf("level_up%0d", l));
      press_start();
    end
    clear_level();
    check("win_flag", 32'(win), 32'd1);
    check_all("win");
    press_start();
    check_all("new_game");
    press_start();

    // Three ball losses
    lose_ball("loss1");
    wait_relaunch("loss1");
    lose_ball("loss2");
    wait_relaunch("loss2");
    lose_ball("loss3");
    check("loss3_game_over", 32'(game_over), 32'd1);
    check("loss3_lives", 32'(lives), 32'd0);
    check("loss_reset_level_total", 32'(obs_rl), 32'(exp_rl));

    // Bottom beats a simultaneous pause edge, then reset inside BALL_LOST
    press_start();
    press_start();
    key_pause = 1; tick();
    step(0, 1, 4'b0000, 1);
    key_pause = 0;
    check_all("bottom_over_pause");
    check("bottom_lives", 32'(lives), 32'd2);
    resetN = 0;
    #1;
    model_reset();
    check("async_reset_level", 32'(reset_level), 32'd0);
    check("async_hit_pulse", 32'(hit_pulse), 32'd0);
    check_all("async_reset");
    @(negedge clk); resetN = 1;
    tick();
    press_start();
    random_frame();
    check_all("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
